// File: rtl/tmr_scrub_regfile.sv
// Triplicated register bank with majority-voted reads and a background scrubber
// that repairs disagreeing copies and reports each repair over a valid/ready channel.
module tmr_scrub_regfile #(
    parameter int WIDTH          = 8,
    parameter int AW             = 3,
    parameter int SCRUB_INTERVAL = 16,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             inj_en,
    input  logic [AW-1:0]    inj_addr,
    input  logic [1:0]       inj_copy,
    input  logic [WIDTH-1:0] inj_mask,
    input  logic             scrub_en,
    output logic [AW-1:0]    scrub_ptr,
    output logic             err_valid,
    input  logic             err_ready,
    output logic [AW-1:0]    err_addr,
    output logic [1:0]       err_copy,
    output logic             err_uncorr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    localparam int               DEPTH      = 2**AW;
    localparam logic [15:0]      TIMER_LAST = 16'(SCRUB_INTERVAL - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {IDLE, WAIT, CHECK, REPORT} state_t;

    state_t           state_q, state_d;
    logic [15:0]      timer_q, timer_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] mem [3][DEPTH];

    logic [WIDTH-1:0] c0, c1, c2, vote;
    logic [WIDTH-1:0] r0, r1, r2;
    logic [2:0]       mism;
    logic             wr_hit, repair, event_uncorr;
    logic [1:0]       event_copy;

    assign r0      = mem[0][rd_addr];
    assign r1      = mem[1][rd_addr];
    assign r2      = mem[2][rd_addr];
    assign rd_data = (r0 & r1) | (r1 & r2) | (r0 & r2);

    assign c0   = mem[0][ptr_q];
    assign c1   = mem[1][ptr_q];
    assign c2   = mem[2][ptr_q];
    assign vote = (c0 & c1) | (c1 & c2) | (c0 & c2);
    assign mism = {c2 != vote, c1 != vote, c0 != vote};

    // A functional write to the word under check supersedes it, so the word counts as clean.
    assign wr_hit       = wr_en && (wr_addr == ptr_q);
    assign repair       = (state_q == CHECK) && !wr_hit && (mism != 3'b000);
    assign event_copy   = mism[0] ? 2'd0 : (mism[1] ? 2'd1 : 2'd2);
    assign event_uncorr = (mism[0] & mism[1]) | (mism[1] & mism[2]) | (mism[0] & mism[2]);

    assign scrub_ptr = ptr_q;
    assign err_valid = (state_q == REPORT);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            timer_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (scrub_en) begin
                    state_d = WAIT;
                    timer_d = '0;
                end
            end
            WAIT: begin
                if (!scrub_en) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = CHECK;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            CHECK: begin
                ptr_d   = ptr_q + AW'(1);
                timer_d = '0;
                if (repair)        state_d = REPORT;
                else if (scrub_en) state_d = WAIT;
                else               state_d = IDLE;
            end
            REPORT: begin
                if (err_ready) begin
                    timer_d = '0;
                    state_d = scrub_en ? WAIT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_addr   <= '0;
            err_copy   <= '0;
            err_uncorr <= 1'b0;
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (repair) begin
            err_addr   <= ptr_q;
            err_copy   <= event_copy;
            err_uncorr <= event_uncorr;
            if (event_uncorr) begin
                if (uncorr_cnt != CNT_MAX) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
            end else begin
                if (corr_cnt != CNT_MAX) corr_cnt <= corr_cnt + CNT_W'(1);
            end
        end
    end

    // Same-address priority: functional write, then scrub repair, then fault injection.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < DEPTH; a++) begin
                if (!rstn)
                    mem[k][a] <= '0;
                else if (wr_en && wr_addr == AW'(a))
                    mem[k][a] <= wr_data;
                else if (repair && ptr_q == AW'(a))
                    mem[k][a] <= vote;
                else if (inj_en && inj_addr == AW'(a) && inj_copy == 2'(k))
                    mem[k][a] <= mem[k][a] ^ inj_mask;
            end
        end
    end

endmodule

// File: tb/tb_tmr_scrub_regfile.sv
// Self-checking bench for tmr_scrub_regfile: directed scenarios plus randomized
// write/inject traffic checked against a per-copy array model of the bank.
module tb_tmr_scrub_regfile;

    localparam int SI     = 4;
    localparam int CNT_MX = 3;

    logic       clk = 1'b0;
    logic       rstn, wr_en, inj_en, scrub_en, err_ready;
    logic [2:0] wr_addr, rd_addr, inj_addr;
    logic [7:0] wr_data, inj_mask, rd_data;
    logic [1:0] inj_copy;
    logic [2:0] scrub_ptr, err_addr;
    logic       err_valid, err_uncorr;
    logic [1:0] err_copy, corr_cnt, uncorr_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] mc [3][8];
    int m_corr, m_uncorr, m_ptr;

    tmr_scrub_regfile #(.WIDTH(8), .AW(3), .SCRUB_INTERVAL(SI), .CNT_W(2)) dut (
        .clk(clk), .rstn(rstn),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .inj_en(inj_en), .inj_addr(inj_addr), .inj_copy(inj_copy), .inj_mask(inj_mask),
        .scrub_en(scrub_en), .scrub_ptr(scrub_ptr),
        .err_valid(err_valid), .err_ready(err_ready),
        .err_addr(err_addr), .err_copy(err_copy), .err_uncorr(err_uncorr),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    always #5 clk = ~clk;

    // Per-bit majority by counting ones across the three model copies.
    function automatic logic [7:0] m_vote(int a);
        logic [7:0] v;
        int n;
        for (int b = 0; b < 8; b++) begin
            n = int'(mc[0][a][b]) + int'(mc[1][a][b]) + int'(mc[2][a][b]);
            v[b] = (n >= 2);
        end
        return v;
    endfunction

    function automatic logic [2:0] m_mism(int a);
        logic [2:0] m;
        logic [7:0] v;
        v = m_vote(a);
        for (int k = 0; k < 3; k++) m[k] = (mc[k][a] != v);
        return m;
    endfunction

    function automatic logic [5:0] m_report(int a);
        logic [2:0] m;
        logic [1:0] c;
        m = m_mism(a);
        c = 2'd0;
        for (int k = 2; k >= 0; k--) if (m[k]) c = 2'(k);
        return {3'(a), c, ($countones(m) >= 2)};
    endfunction

    task automatic model_repair(input int a);
        logic [2:0] m;
        logic [7:0] v;
        m = m_mism(a);
        v = m_vote(a);
        if (m != 3'b000) begin
            for (int k = 0; k < 3; k++) mc[k][a] = v;
            if ($countones(m) >= 2) m_uncorr = (m_uncorr < CNT_MX) ? m_uncorr + 1 : CNT_MX;
            else                    m_corr   = (m_corr   < CNT_MX) ? m_corr   + 1 : CNT_MX;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; wr_en = 1'b0; inj_en = 1'b0; scrub_en = 1'b0; err_ready = 1'b1;
        tick();
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) for (int a = 0; a < 8; a++) mc[k][a] = 8'h00;
        m_corr = 0; m_uncorr = 0; m_ptr = 0;
    endtask

    task automatic do_write(input int a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = 3'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
        for (int k = 0; k < 3; k++) mc[k][a] = d;
    endtask

    task automatic do_inject(input int a, input int k, input logic [7:0] mask);
        inj_en = 1'b1; inj_addr = 3'(a); inj_copy = 2'(k); inj_mask = mask;
        tick();
        inj_en = 1'b0;
        if (k < 3) mc[k][a] = mc[k][a] ^ mask;
    endtask

    task automatic do_both(input int a, input logic [7:0] d, input int b, input int k, input logic [7:0] mask);
        wr_en = 1'b1; wr_addr = 3'(a); wr_data = d;
        inj_en = 1'b1; inj_addr = 3'(b); inj_copy = 2'(k); inj_mask = mask;
        tick();
        wr_en = 1'b0; inj_en = 1'b0;
        if (k < 3 && b != a) mc[k][b] = mc[k][b] ^ mask;
        for (int j = 0; j < 3; j++) mc[j][a] = d;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (err_valid !== 1'b1 && n < limit);
    endtask

    task automatic test_reset();
        do_reset();
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a); #1;
            checks++;
            if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rd[%0d] got %0h expected 00", a, rd_data); end
        end
        checks++;
        if ({err_valid, err_addr, err_copy, err_uncorr} !== 7'd0) begin
            errors++; $display("[TB] FAIL reset_report got %0h expected 0", {err_valid, err_addr, err_copy, err_uncorr});
        end
        checks++;
        if ({corr_cnt, uncorr_cnt} !== 4'd0) begin errors++; $display("[TB] FAIL reset_cnt got %0h expected 0", {corr_cnt, uncorr_cnt}); end
        checks++;
        if (scrub_ptr !== 3'd0) begin errors++; $display("[TB] FAIL reset_ptr got %0d expected 0", scrub_ptr); end
    endtask

    task automatic test_write_read();
        do_write(3, 8'hA5);
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a); #1;
            checks++;
            if (rd_data !== m_vote(a)) begin errors++; $display("[TB] FAIL wr_rd[%0d] got %0h expected %0h", a, rd_data, m_vote(a)); end
        end
        checks++;
        if ({err_valid, corr_cnt, uncorr_cnt} !== 5'd0) begin errors++; $display("[TB] FAIL wr_status got %0h expected 0", {err_valid, corr_cnt, uncorr_cnt}); end
    endtask

    task automatic test_single_repair();
        int n;
        logic [5:0] exp;
        do_reset();
        do_write(2, 8'h3C);
        do_inject(2, 1, 8'hFF);
        rd_addr = 3'd2; #1;
        checks++;
        if (rd_data !== m_vote(2)) begin errors++; $display("[TB] FAIL single_vote got %0h expected %0h", rd_data, m_vote(2)); end
        exp = m_report(2);
        scrub_en = 1'b1; err_ready = 1'b1;
        wait_valid(3 * (SI + 1) + 41, n);
        checks++;
        if (n != 3 * (SI + 1) + 1) begin errors++; $display("[TB] FAIL single_latency got %0d expected %0d", n, 3 * (SI + 1) + 1); end
        model_repair(2);
        checks++;
        if ({err_addr, err_copy, err_uncorr} !== exp) begin errors++; $display("[TB] FAIL single_fields got %0h expected %0h", {err_addr, err_copy, err_uncorr}, exp); end
        checks++;
        if (corr_cnt !== 2'(m_corr) || uncorr_cnt !== 2'(m_uncorr)) begin
            errors++; $display("[TB] FAIL single_cnt got %0d/%0d expected %0d/%0d", corr_cnt, uncorr_cnt, m_corr, m_uncorr);
        end
        scrub_en = 1'b0;
        tick();
        checks++;
        if (err_valid !== 1'b0 || scrub_ptr !== 3'd3) begin errors++; $display("[TB] FAIL single_after got v=%0b p=%0d expected v=0 p=3", err_valid, scrub_ptr); end
        do_inject(2, 3, 8'hFF);
        do_inject(2, 0, 8'hFF);
        rd_addr = 3'd2; #1;
        checks++;
        if (rd_data !== m_vote(2)) begin errors++; $display("[TB] FAIL single_repaired got %0h expected %0h", rd_data, m_vote(2)); end
    endtask

    task automatic test_multi_copy();
        int n;
        logic [5:0] exp;
        do_reset();
        do_write(5, 8'h00);
        do_inject(5, 0, 8'h01);
        do_inject(5, 2, 8'h02);
        exp = m_report(5);
        scrub_en = 1'b1;
        wait_valid(6 * (SI + 1) + 41, n);
        checks++;
        if (n != 6 * (SI + 1) + 1) begin errors++; $display("[TB] FAIL multi_latency got %0d expected %0d", n, 6 * (SI + 1) + 1); end
        model_repair(5);
        checks++;
        if ({err_addr, err_copy, err_uncorr} !== exp) begin errors++; $display("[TB] FAIL multi_fields got %0h expected %0h", {err_addr, err_copy, err_uncorr}, exp); end
        checks++;
        if (corr_cnt !== 2'(m_corr) || uncorr_cnt !== 2'(m_uncorr)) begin
            errors++; $display("[TB] FAIL multi_cnt got %0d/%0d expected %0d/%0d", corr_cnt, uncorr_cnt, m_corr, m_uncorr);
        end
        scrub_en = 1'b0;
        tick();
        rd_addr = 3'd5; #1;
        checks++;
        if (rd_data !== m_vote(5)) begin errors++; $display("[TB] FAIL multi_rd got %0h expected %0h", rd_data, m_vote(5)); end
    endtask

    task automatic test_backpressure();
        int n, stable;
        logic [5:0] exp;
        do_reset();
        do_write(2, 8'h3C);
        do_inject(2, 1, 8'hFF);
        exp = m_report(2);
        err_ready = 1'b0; scrub_en = 1'b1;
        wait_valid(3 * (SI + 1) + 41, n);
        checks++;
        if (n != 3 * (SI + 1) + 1) begin errors++; $display("[TB] FAIL bp_latency got %0d expected %0d", n, 3 * (SI + 1) + 1); end
        model_repair(2);
        stable = 0;
        // A fault arriving during the held report must wait for the scrubber.
        do_inject(3, 2, 8'h40);
        for (int i = 0; i < 50; i++) begin
            if (i > 0) tick();
            if (err_valid === 1'b1 && {err_addr, err_copy, err_uncorr} === exp && scrub_ptr === 3'd3 && corr_cnt === 2'(m_corr))
                stable++;
        end
        checks++;
        if (stable != 50) begin errors++; $display("[TB] FAIL bp_stable got %0d cycles expected 50", stable); end
        exp = m_report(3);
        err_ready = 1'b1;
        wait_valid(SI + 42, n);
        checks++;
        if (n != SI + 2) begin errors++; $display("[TB] FAIL bp_resume got %0d expected %0d", n, SI + 2); end
        model_repair(3);
        checks++;
        if ({err_addr, err_copy, err_uncorr} !== exp || corr_cnt !== 2'(m_corr)) begin
            errors++; $display("[TB] FAIL bp_second got %0h/%0d expected %0h/%0d", {err_addr, err_copy, err_uncorr}, corr_cnt, exp, m_corr);
        end
        scrub_en = 1'b0;
        tick();
    endtask

    task automatic test_priority();
        int seen;
        do_reset();
        do_write(4, 8'h11);
        do_inject(4, 2, 8'h0F);
        scrub_en = 1'b1; err_ready = 1'b1;
        repeat (5 * (SI + 1)) tick();
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h77;
        tick();
        wr_en = 1'b0;
        for (int k = 0; k < 3; k++) mc[k][4] = 8'h77;
        checks++;
        if (scrub_ptr !== 3'd5 || err_valid !== 1'b0) begin errors++; $display("[TB] FAIL prio_state got p=%0d v=%0b expected p=5 v=0", scrub_ptr, err_valid); end
        checks++;
        if (corr_cnt !== 2'(m_corr) || uncorr_cnt !== 2'(m_uncorr)) begin
            errors++; $display("[TB] FAIL prio_cnt got %0d/%0d expected %0d/%0d", corr_cnt, uncorr_cnt, m_corr, m_uncorr);
        end
        seen = 0;
        repeat (3 * (SI + 1)) begin
            tick();
            if (err_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("[TB] FAIL prio_noreport got %0d valid cycles expected 0", seen); end
        scrub_en = 1'b0;
        tick(); tick();
        do_inject(4, 0, 8'hFF);
        rd_addr = 3'd4; #1;
        checks++;
        if (rd_data !== m_vote(4)) begin errors++; $display("[TB] FAIL prio_copies got %0h expected %0h", rd_data, m_vote(4)); end
    endtask

    task automatic test_saturation_reset();
        int n;
        logic [5:0] exp;
        do_reset();
        for (int a = 0; a < 4; a++) do_inject(a, 0, 8'h01);
        scrub_en = 1'b1; err_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = m_report(i);
            wait_valid(SI + 42, n);
            checks++;
            if (n != SI + 2) begin errors++; $display("[TB] FAIL sat_latency[%0d] got %0d expected %0d", i, n, SI + 2); end
            model_repair(i);
            checks++;
            if ({err_addr, err_copy, err_uncorr} !== exp || corr_cnt !== 2'(m_corr)) begin
                errors++; $display("[TB] FAIL sat_report[%0d] got %0h/%0d expected %0h/%0d", i, {err_addr, err_copy, err_uncorr}, corr_cnt, exp, m_corr);
            end
        end
        // Reset lands while the fourth report is still being presented.
        do_reset();
        checks++;
        if ({err_valid, err_addr, err_copy, err_uncorr, corr_cnt, uncorr_cnt, scrub_ptr} !== 14'd0) begin
            errors++; $display("[TB] FAIL sat_reset got %0h expected 0", {err_valid, err_addr, err_copy, err_uncorr, corr_cnt, uncorr_cnt, scrub_ptr});
        end
        do_inject(0, 1, 8'h80);
        exp = m_report(0);
        scrub_en = 1'b1;
        wait_valid(SI + 42, n);
        checks++;
        if (n != SI + 2) begin errors++; $display("[TB] FAIL sat_idle_restart got %0d expected %0d", n, SI + 2); end
        model_repair(0);
        checks++;
        if ({err_addr, err_copy, err_uncorr} !== exp || corr_cnt !== 2'(m_corr)) begin
            errors++; $display("[TB] FAIL sat_after got %0h/%0d expected %0h/%0d", {err_addr, err_copy, err_uncorr}, corr_cnt, exp, m_corr);
        end
        scrub_en = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int a, b, k, n, p, clean, last, exp_n;
        logic [5:0] exp;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 40; i++) begin
                a = $urandom_range(0, 7); b = $urandom_range(0, 7); k = $urandom_range(0, 3);
                case ($urandom_range(0, 2))
                    0:       do_write(a, 8'($urandom));
                    1:       do_inject(b, k, 8'($urandom));
                    default: do_both(a, 8'($urandom), b, k, 8'($urandom));
                endcase
                a = $urandom_range(0, 7);
                rd_addr = 3'(a); #1;
                checks++;
                if (rd_data !== m_vote(a)) begin errors++; $display("[TB] FAIL rnd_rd[%0d] got %0h expected %0h", a, rd_data, m_vote(a)); end
            end
            clean = 0; last = -1;
            for (int j = 0; j < 8; j++) begin
                p = (m_ptr + j) % 8;
                if (m_mism(p) != 3'b000) begin
                    exp_n = (clean + 1) * (SI + 1) + 1;
                    exp = m_report(p);
                    scrub_en = 1'b1;
                    wait_valid(exp_n + 40, n);
                    checks++;
                    if (n != exp_n) begin errors++; $display("[TB] FAIL rnd_latency[%0d] got %0d expected %0d", p, n, exp_n); end
                    model_repair(p);
                    checks++;
                    if ({err_addr, err_copy, err_uncorr} !== exp) begin
                        errors++; $display("[TB] FAIL rnd_fields[%0d] got %0h expected %0h", p, {err_addr, err_copy, err_uncorr}, exp);
                    end
                    checks++;
                    if (corr_cnt !== 2'(m_corr) || uncorr_cnt !== 2'(m_uncorr)) begin
                        errors++; $display("[TB] FAIL rnd_cnt got %0d/%0d expected %0d/%0d", corr_cnt, uncorr_cnt, m_corr, m_uncorr);
                    end
                    clean = 0; last = p;
                end else begin
                    clean++;
                end
            end
            if (last >= 0) m_ptr = (last + 1) % 8;
            scrub_en = 1'b0;
            tick(); tick();
            checks++;
            if (scrub_ptr !== 3'(m_ptr)) begin errors++; $display("[TB] FAIL rnd_ptr got %0d expected %0d", scrub_ptr, m_ptr); end
            for (int q = 0; q < 8; q++) begin
                rd_addr = 3'(q); #1;
                checks++;
                if (rd_data !== m_vote(q)) begin errors++; $display("[TB] FAIL rnd_sweep[%0d] got %0h expected %0h", q, rd_data, m_vote(q)); end
            end
        end
    endtask

    initial begin
        rstn = 1'b0; wr_en = 1'b0; inj_en = 1'b0; scrub_en = 1'b0; err_ready = 1'b1;
        wr_addr = '0; wr_data = '0; rd_addr = '0; inj_addr = '0; inj_copy = '0; inj_mask = '0;
        test_reset();
        test_write_read();
        test_single_repair();
        test_multi_copy();
        test_backpressure();
        test_priority();
        test_saturation_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
